// File: rtl/batch_collector.sv
// Collects accepted transaction IDs into a batch buffer and drains each closed
// batch downstream one ID per beat; batches close on full, idle timeout or flush.
module batch_collector #(
   parameter int ID_W           = 64,
   parameter int BATCH_SIZE     = 8,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = $clog2(BATCH_SIZE + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             insertion_ready,
   input  logic [ID_W-1:0]  owner_programID,
   input  logic             force_flush,
   output logic             pipeline_ready,
   output logic [ID_W-1:0]  accepted_id,
   output logic             accepted_valid,
   output logic             batch_out_valid,
   output logic [ID_W-1:0]  batch_out_id,
   output logic             batch_out_last,
   output logic [CNT_W-1:0] batch_out_size,
   input  logic             batch_out_ready,
   output logic [15:0]      batches_done,
   output logic             dbg_state
);

   localparam int IDX_W = $clog2(BATCH_SIZE);
   localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TO_W-1:0]  TO_LAST = (TIMEOUT_CYCLES > 0) ? TO_W'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic [CNT_W-1:0] FULL    = CNT_W'(BATCH_SIZE);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   typedef enum logic {
      COLLECT = 1'b0,
      DRAIN   = 1'b1
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] rd;
   logic [TO_W-1:0]  idle_cnt;
   logic [ID_W-1:0]  buffer [BATCH_SIZE];

   logic             accept;
   logic             fill_now;
   logic             flush_now;
   logic             timeout_now;
   logic             go_drain;
   logic             beat_done;
   logic [CNT_W-1:0] count_nxt;
   logic [CNT_W-1:0] rd_nxt;
   logic [ID_W-1:0]  first_id;

   // Handshakes: upstream transfers when insertion_ready && pipeline_ready at a
   // posedge; downstream transfers when batch_out_valid && batch_out_ready at a
   // posedge. A presented beat holds id/last stable until it transfers.
   assign pipeline_ready = (state == COLLECT) && (count < FULL);
   assign accept         = insertion_ready && pipeline_ready;
   assign count_nxt      = count + CNT_W'(accept);

   assign fill_now    = accept && (count_nxt == FULL);
   assign flush_now   = force_flush && (state == COLLECT) && (count_nxt != '0);
   assign timeout_now = (TIMEOUT_CYCLES > 0) && (state == COLLECT) && (count != '0)
                        && !accept && (idle_cnt == TO_LAST);
   assign go_drain    = fill_now || flush_now || timeout_now;

   // A flush that accepts into an empty buffer must present the new ID directly.
   assign first_id  = (count == '0) ? owner_programID : buffer[0];
   assign beat_done = batch_out_valid && batch_out_ready;
   assign rd_nxt    = rd + ONE;
   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (accept) begin
         buffer[count[IDX_W-1:0]] <= owner_programID;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= COLLECT;
         count           <= '0;
         rd              <= '0;
         idle_cnt        <= '0;
         batches_done    <= '0;
         accepted_valid  <= 1'b0;
         accepted_id     <= '0;
         batch_out_valid <= 1'b0;
         batch_out_last  <= 1'b0;
         batch_out_size  <= '0;
         batch_out_id    <= '0;
      end else begin
         accepted_valid <= accept;
         if (accept) begin
            accepted_id <= owner_programID;
         end

         case (state)
            COLLECT: begin
               count <= count_nxt;
               if (go_drain) begin
                  state           <= DRAIN;
                  idle_cnt        <= '0;
                  rd              <= '0;
                  batch_out_valid <= 1'b1;
                  batch_out_id    <= first_id;
                  batch_out_last  <= (count_nxt == ONE);
                  batch_out_size  <= count_nxt;
               end else if (accept || (count == '0)) begin
                  idle_cnt <= '0;
               end else begin
                  idle_cnt <= idle_cnt + TO_W'(1);
               end
            end

            DRAIN: begin
               if (beat_done) begin
                  if (batch_out_last) begin
                     state           <= COLLECT;
                     batch_out_valid <= 1'b0;
                     batch_out_last  <= 1'b0;
                     count           <= '0;
                     rd              <= '0;
                     batches_done    <= batches_done + 16'd1;
                  end else begin
                     rd             <= rd_nxt;
                     batch_out_id   <= buffer[rd_nxt[IDX_W-1:0]];
                     batch_out_last <= (rd_nxt == (batch_out_size - ONE));
                  end
               end
            end

            default: state <= COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_batch_collector.sv
// Scenario bench for batch_collector: each task drives one scenario and checks
// echoes and drained beats against an expected-ID queue.
module tb_batch_collector;

   localparam int ID_W  = 64;
   localparam int BS    = 8;
   localparam int TO    = 16;
   localparam int CNT_W = $clog2(BS + 1);

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             insertion_ready = 1'b0;
   logic [ID_W-1:0]  owner_programID = '0;
   logic             force_flush = 1'b0;
   logic             batch_out_ready = 1'b0;
   logic             pipeline_ready;
   logic [ID_W-1:0]  accepted_id;
   logic             accepted_valid;
   logic             batch_out_valid;
   logic [ID_W-1:0]  batch_out_id;
   logic             batch_out_last;
   logic [CNT_W-1:0] batch_out_size;
   logic [15:0]      batches_done;
   logic             dbg_state;

   logic [ID_W-1:0] exp_q[$];
   int n_cmp = 0;
   int n_bad = 0;
   int exp_done = 0;

   always #5 clk = ~clk;

   batch_collector #(
      .ID_W(ID_W), .BATCH_SIZE(BS), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .insertion_ready(insertion_ready), .owner_programID(owner_programID),
      .force_flush(force_flush), .pipeline_ready(pipeline_ready),
      .accepted_id(accepted_id), .accepted_valid(accepted_valid),
      .batch_out_valid(batch_out_valid), .batch_out_id(batch_out_id),
      .batch_out_last(batch_out_last), .batch_out_size(batch_out_size),
      .batch_out_ready(batch_out_ready), .batches_done(batches_done),
      .dbg_state(dbg_state)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      insertion_ready = 1'b0;
      force_flush = 1'b0;
      batch_out_ready = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      exp_q.delete();
      exp_done = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      insertion_ready = 1'b1;
      owner_programID = 64'h99;
      force_flush = 1'b0;
      batch_out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (accepted_valid !== 1'b0) begin n_bad++; $display("FAIL rst_acc_valid: got %0b want 0", accepted_valid); end
         n_cmp++; if (accepted_id !== '0) begin n_bad++; $display("FAIL rst_acc_id: got %0h want 0", accepted_id); end
         n_cmp++; if (batch_out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %0b want 0", batch_out_valid); end
         n_cmp++; if (batch_out_id !== '0) begin n_bad++; $display("FAIL rst_out_id: got %0h want 0", batch_out_id); end
         n_cmp++; if (batch_out_last !== 1'b0) begin n_bad++; $display("FAIL rst_out_last: got %0b want 0", batch_out_last); end
         n_cmp++; if (batch_out_size !== '0) begin n_bad++; $display("FAIL rst_out_size: got %0d want 0", batch_out_size); end
         n_cmp++; if (batches_done !== 16'd0) begin n_bad++; $display("FAIL rst_done: got %0d want 0", batches_done); end
         n_cmp++; if (pipeline_ready !== 1'b1) begin n_bad++; $display("FAIL rst_pready: got %0b want 1", pipeline_ready); end
      end
      rst_n = 1'b1;
      tick();
      insertion_ready = 1'b0;
      n_cmp++; if (accepted_valid !== 1'b1) begin n_bad++; $display("FAIL rst_first_acc: got %0b want 1", accepted_valid); end
      n_cmp++; if (accepted_id !== 64'h99) begin n_bad++; $display("FAIL rst_first_id: got %0h want 99", accepted_id); end
   endtask

   task automatic test_back_to_back();
      bit done;
      int beats;
      int cyc;
      done = 1'b0;
      beats = 0;
      cyc = 0;
      do_reset();
      batch_out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         insertion_ready = 1'b1;
         owner_programID = 64'(16 + i);
         exp_q.push_back(64'(16 + i));
         tick();
         n_cmp++; if (accepted_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_echo_valid[%0d]: got %0b want 1", i, accepted_valid); end
         n_cmp++; if (accepted_id !== 64'(16 + i)) begin n_bad++; $display("FAIL b2b_echo_id[%0d]: got %0h want %0h", i, accepted_id, 16 + i); end
      end
      owner_programID = 64'hDEAD;
      n_cmp++; if (pipeline_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_pready_drop: got %0b want 0", pipeline_ready); end
      for (int c = 0; c < 20 && !done; c++) begin
         if (c > 0) begin
            n_cmp++; if (accepted_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_ignored_insert: got %0b want 0", accepted_valid); end
         end
         if (batch_out_valid) begin
            beats++;
            if (exp_q.size() == 0) begin
               n_cmp++; n_bad++; $display("FAIL b2b_extra_beat: got id %0h want none", batch_out_id);
               done = 1'b1;
            end else begin
               n_cmp++; if (batch_out_id !== exp_q[0]) begin n_bad++; $display("FAIL b2b_beat_id: got %0h want %0h", batch_out_id, exp_q[0]); end
               n_cmp++; if (batch_out_last !== (exp_q.size() == 1)) begin n_bad++; $display("FAIL b2b_beat_last: got %0b want %0b", batch_out_last, exp_q.size() == 1); end
               n_cmp++; if (batch_out_size !== CNT_W'(8)) begin n_bad++; $display("FAIL b2b_size: got %0d want 8", batch_out_size); end
               void'(exp_q.pop_front());
               if (exp_q.size() == 0) begin
                  done = 1'b1;
                  insertion_ready = 1'b0;
                  exp_done++;
               end
            end
         end
         tick();
         cyc++;
      end
      n_cmp++; if (!done) begin n_bad++; $display("FAIL b2b_drain_timeout: got %0d beats want 8", beats); end
      n_cmp++; if (beats !== 8 || cyc !== 8) begin n_bad++; $display("FAIL b2b_beat_count: got %0d beats in %0d cycles want 8 in 8", beats, cyc); end
      n_cmp++; if (batch_out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_valid_after: got %0b want 0", batch_out_valid); end
      n_cmp++; if (pipeline_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_pready_back: got %0b want 1", pipeline_ready); end
      n_cmp++; if (batches_done !== 16'(exp_done)) begin n_bad++; $display("FAIL b2b_done: got %0d want %0d", batches_done, exp_done); end
      n_cmp++; if (accepted_id !== 64'h17) begin n_bad++; $display("FAIL b2b_id_hold: got %0h want 17", accepted_id); end
   endtask

   task automatic test_timeout();
      bit done;
      int early;
      done = 1'b0;
      early = 0;
      do_reset();
      batch_out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         insertion_ready = 1'b1;
         owner_programID = 64'(10 + i);
         exp_q.push_back(64'(10 + i));
         tick();
      end
      insertion_ready = 1'b0;
      for (int k = 1; k <= TO; k++) begin
         tick();
         if (k < TO && batch_out_valid !== 1'b0) early++;
      end
      n_cmp++; if (early != 0) begin n_bad++; $display("FAIL to_early: got %0d early valid cycles want 0", early); end
      n_cmp++; if (batch_out_valid !== 1'b1) begin n_bad++; $display("FAIL to_start: got %0b want 1", batch_out_valid); end
      for (int c = 0; c < 10 && !done; c++) begin
         if (batch_out_valid) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_bad++; $display("FAIL to_extra_beat: got id %0h want none", batch_out_id);
               done = 1'b1;
            end else begin
               n_cmp++; if (batch_out_id !== exp_q[0]) begin n_bad++; $display("FAIL to_beat_id: got %0h want %0h", batch_out_id, exp_q[0]); end
               n_cmp++; if (batch_out_last !== (exp_q.size() == 1)) begin n_bad++; $display("FAIL to_beat_last: got %0b want %0b", batch_out_last, exp_q.size() == 1); end
               n_cmp++; if (batch_out_size !== CNT_W'(3)) begin n_bad++; $display("FAIL to_size: got %0d want 3", batch_out_size); end
               void'(exp_q.pop_front());
               if (exp_q.size() == 0) begin done = 1'b1; exp_done++; end
            end
         end
         tick();
      end
      n_cmp++; if (!done) begin n_bad++; $display("FAIL to_drain_timeout: got %0d left want 0", exp_q.size()); end
      n_cmp++; if (batches_done !== 16'(exp_done)) begin n_bad++; $display("FAIL to_done: got %0d want %0d", batches_done, exp_done); end
   endtask

   task automatic test_stall();
      bit done;
      bit [3:0] pat;
      done = 1'b0;
      pat = 4'b1001;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         insertion_ready = 1'b1;
         owner_programID = {$urandom, $urandom};
         exp_q.push_back(owner_programID);
         tick();
      end
      insertion_ready = 1'b0;
      force_flush = 1'b1;
      tick();
      force_flush = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         batch_out_ready = pat[c % 4];
         n_cmp++; if (pipeline_ready !== 1'b0) begin n_bad++; $display("FAIL stall_pready: got %0b want 0", pipeline_ready); end
         if (!batch_out_valid) begin
            n_cmp++; n_bad++; $display("FAIL stall_bubble: got valid 0 want 1 with %0d left", exp_q.size());
            done = 1'b1;
         end else if (exp_q.size() == 0) begin
            n_cmp++; n_bad++; $display("FAIL stall_extra_beat: got id %0h want none", batch_out_id);
            done = 1'b1;
         end else begin
            n_cmp++; if (batch_out_id !== exp_q[0]) begin n_bad++; $display("FAIL stall_beat_id: got %0h want %0h", batch_out_id, exp_q[0]); end
            n_cmp++; if (batch_out_last !== (exp_q.size() == 1)) begin n_bad++; $display("FAIL stall_beat_last: got %0b want %0b", batch_out_last, exp_q.size() == 1); end
            n_cmp++; if (batch_out_size !== CNT_W'(5)) begin n_bad++; $display("FAIL stall_size: got %0d want 5", batch_out_size); end
            if (batch_out_ready) begin
               void'(exp_q.pop_front());
               if (exp_q.size() == 0) begin done = 1'b1; exp_done++; end
            end
         end
         tick();
      end
      n_cmp++; if (!done || exp_q.size() != 0) begin n_bad++; $display("FAIL stall_drain_timeout: got %0d left want 0", exp_q.size()); end
      n_cmp++; if (batch_out_valid !== 1'b0) begin n_bad++; $display("FAIL stall_valid_after: got %0b want 0", batch_out_valid); end
      n_cmp++; if (batches_done !== 16'(exp_done)) begin n_bad++; $display("FAIL stall_done: got %0d want %0d", batches_done, exp_done); end
   endtask

   task automatic test_flush();
      do_reset();
      batch_out_ready = 1'b1;
      insertion_ready = 1'b1;
      owner_programID = 64'h55;
      force_flush = 1'b1;
      tick();
      insertion_ready = 1'b0;
      force_flush = 1'b0;
      n_cmp++; if (accepted_valid !== 1'b1) begin n_bad++; $display("FAIL flush_acc: got %0b want 1", accepted_valid); end
      n_cmp++; if (batch_out_valid !== 1'b1) begin n_bad++; $display("FAIL flush_valid: got %0b want 1", batch_out_valid); end
      n_cmp++; if (batch_out_id !== 64'h55) begin n_bad++; $display("FAIL flush_id: got %0h want 55", batch_out_id); end
      n_cmp++; if (batch_out_last !== 1'b1) begin n_bad++; $display("FAIL flush_last: got %0b want 1", batch_out_last); end
      n_cmp++; if (batch_out_size !== CNT_W'(1)) begin n_bad++; $display("FAIL flush_size: got %0d want 1", batch_out_size); end
      tick();
      exp_done++;
      n_cmp++; if (batch_out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_end: got %0b want 0", batch_out_valid); end
      force_flush = 1'b1;
      tick();
      force_flush = 1'b0;
      tick();
      n_cmp++; if (batch_out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_empty_beat: got %0b want 0", batch_out_valid); end
      n_cmp++; if (pipeline_ready !== 1'b1) begin n_bad++; $display("FAIL flush_empty_pready: got %0b want 1", pipeline_ready); end
      n_cmp++; if (batches_done !== 16'(exp_done)) begin n_bad++; $display("FAIL flush_done: got %0d want %0d", batches_done, exp_done); end
   endtask

   task automatic test_reset_mid_drain();
      bit done;
      logic [ID_W-1:0] ids [5];
      done = 1'b0;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         ids[i] = 64'(32'h300 + i);
         insertion_ready = 1'b1;
         owner_programID = ids[i];
         tick();
      end
      insertion_ready = 1'b0;
      force_flush = 1'b1;
      tick();
      force_flush = 1'b0;
      batch_out_ready = 1'b1;
      n_cmp++; if (batch_out_id !== ids[0]) begin n_bad++; $display("FAIL mid_beat1: got %0h want %0h", batch_out_id, ids[0]); end
      tick();
      n_cmp++; if (batch_out_id !== ids[1]) begin n_bad++; $display("FAIL mid_beat2: got %0h want %0h", batch_out_id, ids[1]); end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_q.delete();
      exp_done = 0;
      n_cmp++; if (batch_out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid: got %0b want 0", batch_out_valid); end
      n_cmp++; if (batches_done !== 16'd0) begin n_bad++; $display("FAIL mid_done: got %0d want 0", batches_done); end
      n_cmp++; if (pipeline_ready !== 1'b1) begin n_bad++; $display("FAIL mid_pready: got %0b want 1", pipeline_ready); end
      for (int i = 0; i < 2; i++) begin
         insertion_ready = 1'b1;
         owner_programID = 64'(32'h77 + i);
         exp_q.push_back(64'(32'h77 + i));
         force_flush = (i == 1);
         tick();
      end
      insertion_ready = 1'b0;
      force_flush = 1'b0;
      for (int c = 0; c < 10 && !done; c++) begin
         if (batch_out_valid) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_bad++; $display("FAIL mid_extra_beat: got id %0h want none", batch_out_id);
               done = 1'b1;
            end else begin
               n_cmp++; if (batch_out_id !== exp_q[0]) begin n_bad++; $display("FAIL mid_next_id: got %0h want %0h", batch_out_id, exp_q[0]); end
               n_cmp++; if (batch_out_size !== CNT_W'(2)) begin n_bad++; $display("FAIL mid_next_size: got %0d want 2", batch_out_size); end
               void'(exp_q.pop_front());
               if (exp_q.size() == 0) begin done = 1'b1; exp_done++; end
            end
         end
         tick();
      end
      n_cmp++; if (!done) begin n_bad++; $display("FAIL mid_next_timeout: got %0d left want 0", exp_q.size()); end
      n_cmp++; if (batches_done !== 16'(exp_done)) begin n_bad++; $display("FAIL mid_next_done: got %0d want %0d", batches_done, exp_done); end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_timeout();
      test_stall();
      test_flush();
      test_reset_mid_drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
